// File: rtl/cic_i_if.sv
// Sample-stream bundle for the CIC interpolator: low-rate input handshake
// and high-rate output stream.
interface cic_i_if #(
  parameter int idw = 8,
  parameter int odw = 8
);
  logic signed [idw-1:0] data_in;
  logic                  in_dv;
  logic                  in_ready;
  logic signed [odw-1:0] data_out;
  logic                  out_dv;

  modport master (
    output data_in,
    output in_dv,
    input  in_ready,
    input  data_out,
    input  out_dv
  );

  modport slave (
    input  data_in,
    input  in_dv,
    output in_ready,
    output data_out,
    output out_dv
  );
endinterface

// File: rtl/cic_i.sv
// CIC interpolator: m combs at the input rate, zero-stuffing upsampler by r,
// m integrators at the clock rate, output truncated to the top odw bits.
module cic_i #(
  parameter int idw = 8,
  parameter int odw = 8,
  parameter int r   = 4,
  parameter int m   = 4,
  parameter int g   = 1
) (
  input  logic    clk,
  input  logic    reset,
  cic_i_if.slave  bus
);

  localparam int growth = $clog2(((r * g) ** m) / r);
  localparam int b_max  = idw + growth;
  localparam int cw     = idw + m;
  localparam int cntw   = (r > 1) ? $clog2(r) : 1;

  logic [cntw-1:0] cnt_q, cnt_d;
  logic            accept;

  assign bus.in_ready = !reset && (cnt_q == '0);
  assign accept       = bus.in_dv && bus.in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = cntw'(r - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Comb chain: stage k is idw+k bits; each delay line advances only on accept.
  for (genvar k = 1; k <= m; k++) begin : g_comb
    localparam int w = idw + k;
    logic signed [w-1:0] x;
    logic signed [w-1:0] y;
    logic signed [w-1:0] dly_q [g];

    if (k == 1) begin : g_first
      assign x = w'(bus.data_in);
    end else begin : g_next
      assign x = w'(g_comb[k-1].y);
    end

    assign y = x - dly_q[g-1];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < g; i++) begin
          dly_q[i] <= '0;
        end
      end else if (accept) begin
        dly_q[0] <= x;
        for (int i = 1; i < g; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end
  end

  logic signed [b_max-1:0] comb_m;

  // Modulo arithmetic downstream makes dropping the top comb bits harmless.
  if (cw > b_max) begin : g_trunc
    assign comb_m = g_comb[m].y[b_max-1:0];
  end else begin : g_sext
    assign comb_m = b_max'(g_comb[m].y);
  end

  logic signed [b_max-1:0] us_q, us_d;
  logic                    us_v_q, us_v_d;

  always_comb begin
    us_d   = us_q;
    us_v_d = 1'b0;
    if (accept) begin
      us_d   = comb_m;
      us_v_d = 1'b1;
    end else if (cnt_q != '0) begin
      us_d   = '0;
      us_v_d = 1'b1;
    end
  end

  logic signed [b_max-1:0] integ_q [m];
  logic signed [b_max-1:0] integ_d [m];
  logic        [m-1:0]     v_q, v_d;

  // Integrators wrap freely; a low valid freezes the stage.
  always_comb begin
    for (int i = 0; i < m; i++) begin
      integ_d[i] = integ_q[i];
    end
    v_d[0] = us_v_q;
    if (us_v_q) begin
      integ_d[0] = integ_q[0] + us_q;
    end
    for (int i = 1; i < m; i++) begin
      v_d[i] = v_q[i-1];
      if (v_q[i-1]) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      us_q   <= '0;
      us_v_q <= 1'b0;
      v_q    <= '0;
      for (int i = 0; i < m; i++) begin
        integ_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      us_q   <= us_d;
      us_v_q <= us_v_d;
      v_q    <= v_d;
      for (int i = 0; i < m; i++) begin
        integ_q[i] <= integ_d[i];
      end
    end
  end

  assign bus.data_out = integ_q[m-1][b_max-1 -: odw];
  assign bus.out_dv   = v_q[m-1];

endmodule

// File: tb/tb_cic_i.sv
// Bench for cic_i: four configurations checked cycle by cycle against a
// convolution model of the overall interpolator response.
module tb_cic_i;

  typedef struct {
    longint cyc;
    longint val;
  } ev_t;

  logic clk;
  logic reset;
  logic signed [7:0] din [4];
  logic              dv  [4];
  logic              rdy [4];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // cfg0: m1 r4 g1 odw8 | cfg1: m4 r4 g1 odw8 | cfg2: m4 r4 g1 odw14 | cfg3: m2 r1 g2 odw10
  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int IDW = 8;
    localparam int R   = (gi == 3) ? 1 : 4;
    localparam int M   = (gi == 0) ? 1 : ((gi == 3) ? 2 : 4);
    localparam int G   = (gi == 3) ? 2 : 1;
    localparam int ODW = (gi == 2) ? 14 : ((gi == 3) ? 10 : 8);
    localparam int B   = IDW + $clog2(((R * G) ** M) / R);

    cic_i_if #(.idw(IDW), .odw(ODW)) bus ();

    cic_i #(.idw(IDW), .odw(ODW), .r(R), .m(M), .g(G)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );

    assign bus.data_in = din[gi];
    assign bus.in_dv   = dv[gi];
    assign rdy[gi]     = bus.in_ready;

    longint h[$];
    longint u[$];
    ev_t    q[$];
    longint cyc_n    = 0;
    longint last_acc = -100;
    longint held     = 0;
    longint osum     = 0;

    function automatic longint trunc(longint v);
      longint b;
      b = v & ((longint'(1) << B) - 1);
      if (b >= (longint'(1) << (B - 1))) b = b - (longint'(1) << B);
      return b >>> (B - ODW);
    endfunction

    // Overall high-rate response: (1 + z^-1 + ... + z^-(RG-1))^M
    initial begin
      longint t[$];
      longint s;
      h.push_back(1);
      repeat (M) begin
        t = {};
        for (int k = 0; k < h.size() + R * G - 1; k++) begin
          s = 0;
          for (int j = 0; j < R * G; j++)
            if (k - j >= 0 && k - j < h.size()) s = s + h[k-j];
          t.push_back(s);
        end
        h = t;
      end
    end

    always @(negedge clk) begin
      bit     er, edv;
      longint x, y;
      int     n;
      er = !reset && (cyc_n - last_acc >= R);
      chk($sformatf("cfg%0d ready @%0d", gi, cyc_n), longint'(bus.in_ready), longint'(er));
      if (reset) begin
        chk($sformatf("cfg%0d rst out_dv @%0d", gi, cyc_n), longint'(bus.out_dv), 0);
        chk($sformatf("cfg%0d rst data @%0d", gi, cyc_n), longint'($signed(bus.data_out)), 0);
        u.delete();
        q.delete();
        last_acc = cyc_n - R;
        held = 0;
      end else begin
        edv = 1'b0;
        if (q.size() > 0 && q[0].cyc == cyc_n) begin
          held = trunc(q[0].val);
          void'(q.pop_front());
          edv = 1'b1;
        end
        chk($sformatf("cfg%0d out_dv @%0d", gi, cyc_n), longint'(bus.out_dv), longint'(edv));
        chk($sformatf("cfg%0d data @%0d", gi, cyc_n), longint'($signed(bus.data_out)), held);
        if (bus.out_dv) osum = osum + longint'($signed(bus.data_out));
        if (bus.in_dv && er) begin
          x = longint'($signed(bus.data_in));
          last_acc = cyc_n;
          for (int j = 0; j < R; j++) begin
            u.push_back((j == 0) ? x : 0);
            n = u.size() - 1;
            y = 0;
            for (int k = 0; k < h.size() && k <= n; k++) y = y + h[k] * u[n-k];
            q.push_back('{cyc_n + M + 1 + j, y});
          end
        end
      end
      cyc_n++;
    end
  end

  // kind: 0 const, 1 random, 2 impulse, 3 alternating 5/-3
  task automatic run(input int idx, input int nsamp, input int kind, input int cval,
                     input int stall_at, input int stall_p, input int rst_at);
    int acc = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    bit dvv;
    logic signed [7:0] x;
    while (acc < nsamp && cyc < 3000) begin
      case (kind)
        0:       x = 8'(cval);
        1:       x = 8'($urandom);
        2:       x = (acc == 0) ? 8'sd1 : 8'sd0;
        default: x = (acc % 2 == 0) ? 8'sd5 : -8'sd3;
      endcase
      if (cyc == rst_at) reset = 1'b1;
      if (cyc == rst_at + 2) reset = 1'b0;
      if (acc == stall_at && !stalled && rdy[idx]) begin
        stall_left = 3;
        stalled = 1'b1;
      end
      dvv = (stall_left == 0) && ($urandom_range(99) >= stall_p);
      if (stall_left > 0) stall_left--;
      if (!dvv) x = 8'($urandom);
      dv[idx]  = dvv;
      din[idx] = x;
      @(negedge clk);
      if (dv[idx] && rdy[idx]) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk($sformatf("run cfg%0d samples", idx), acc, nsamp);
    dv[idx] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    longint s0;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dv[i]  = 1'b0;
      din[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    run(0, 2, 3, 0, -1, 0, -1);
    idle(10);
    run(0, 4, 3, 0, 1, 0, -1);
    idle(10);
    run(0, 40, 1, 0, -1, 20, -1);
    idle(10);

    run(1, 30, 0, 10, -1, 0, -1);
    chk("dc pos", longint'($signed(g_cfg[1].bus.data_out)), 10);
    run(1, 30, 0, -128, -1, 0, -1);
    chk("dc neg", longint'($signed(g_cfg[1].bus.data_out)), -128);
    idle(10);
    run(1, 30, 0, 10, -1, 0, 40);
    chk("dc after reset", longint'($signed(g_cfg[1].bus.data_out)), 10);
    idle(10);
    run(1, 40, 1, 0, 5, 15, -1);
    idle(20);

    s0 = g_cfg[2].osum;
    run(2, 20, 2, 0, -1, 0, -1);
    idle(20);
    chk("impulse sum", g_cfg[2].osum - s0, 256);
    run(2, 60, 1, 0, -1, 15, -1);
    idle(20);

    run(3, 80, 1, 0, 10, 25, -1);
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
